iomem_arbiter: RTL and testbench

Two-master round-robin arbiter sharing the single PicoSoC iomem peripheral port, for example the GPIO/LED register at 0x03xx_xxxx, between the CPU and a second requester such as a debug or DMA engine. It sits between the requesters and the existing iomem slave logic. It grants one transaction at a time and forwards the winning request unchanged. It registers the slave's response and returns it to the winner as a one-cycle ready pulse, with an optional watchdog for slaves that never answer.

---
 rtl/iomem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_iomem_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter in front of the PicoSoC iomem slave port.
// Define IOMEM_ARB_TIMEOUT_EN to build the watchdog for slaves that never answer.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,

  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q;
  logic        last_owner_q;
  logic        grant;
  logic        any_req;
  logic [31:0] rdata_q;
  logic        timeout_err_q;
  logic        wdog_fire;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wdog_q;

  // Cleared while idle so every BUSY entry starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= 8'd0;
    end else if (state_q != StBusy) begin
      wdog_q <= 8'd0;
    end else if (!s_ready) begin
      wdog_q <= wdog_q + 8'd1;
    end
  end

  // A same-cycle s_ready takes precedence over the watchdog.
  assign wdog_fire = (state_q == StBusy) && !s_ready && (wdog_q == WdogLast);
`else
  localparam logic [7:0] UnusedLimit = 8'(TIMEOUT_CYCLES);

  logic unused_timeout;
  assign unused_timeout = ^UnusedLimit;
  assign wdog_fire      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin pick: on contention the master that did not win last time goes first.
  always_comb begin
    any_req = m0_valid || m1_valid;
    if (m0_valid && m1_valid) begin
      grant = ~last_owner_q;
    end else begin
      grant = m1_valid;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (s_ready || wdog_fire) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ownership and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      rdata_q       <= 32'h0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle && any_req) begin
        owner_q <= grant;
      end
      if (state_q == StBusy) begin
        if (s_ready) begin
          rdata_q      <= s_rdata;
          last_owner_q <= owner_q;
        end else if (wdog_fire) begin
          rdata_q       <= 32'hFFFF_FFFF;
          timeout_err_q <= 1'b1;
          last_owner_q  <= owner_q;
        end
      end
    end
  end

  // Outputs depend only on registered state, so s_ready never reaches m*_ready combinationally.
  always_comb begin
    s_valid  = 1'b0;
    s_wstrb  = 4'h0;
    s_addr   = 32'h0;
    s_wdata  = 32'h0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    if (state_q == StBusy) begin
      s_valid = 1'b1;
      if (owner_q) begin
        s_wstrb = m1_wstrb;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end else begin
        s_wstrb = m0_wstrb;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
    end
    if (state_q == StResp) begin
      m0_ready = ~owner_q;
      m1_ready = owner_q;
    end
  end

  assign m0_rdata    = rdata_q;
  assign m1_rdata    = rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter: queued master requests, a behavioural slave,
// and expected completions popped as ready pulses appear.
module tb_iomem_arbiter;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic        master;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t exp_q[$];
  req_t m0_pend[$];
  req_t m1_pend[$];
  int   load_cyc0, load_cyc1, last_lat;
  int   m0_pulses = 0;
  int   m1_pulses = 0;

  int          slave_lat = 0;
  bit          slave_silent = 0;
  logic [31:0] slave_key = 32'h0;
  int          busy_cnt = 0;
  bit          in_acc = 0;
  logic [31:0] acc_addr[$];
  logic [31:0] acc_wdata[$];
  logic [3:0]  acc_wstrb[$];

  iomem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_wstrb    (m0_wstrb),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_wstrb    (m1_wstrb),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_wstrb     (s_wstrb),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] slave_val(input logic [31:0] a, input logic [31:0] w);
    return a ^ w ^ slave_key;
  endfunction

  // Behavioural slave: answers slave_lat cycles after s_valid rises unless silenced.
  always @(negedge clk) begin
    if (!s_valid) begin
      in_acc   = 0;
      busy_cnt = 0;
      s_ready  = 1'b0;
    end else begin
      if (!in_acc) begin
        in_acc = 1;
        acc_addr.push_back(s_addr);
        acc_wdata.push_back(s_wdata);
        acc_wstrb.push_back(s_wstrb);
      end
      if (!slave_silent && busy_cnt >= slave_lat) begin
        s_ready = 1'b1;
        s_rdata = slave_val(s_addr, s_wdata);
      end else begin
        s_ready = 1'b0;
        if (!slave_silent) busy_cnt++;
      end
    end
  end

  // Master drivers: hold valid until ready, then load the next queued request.
  always @(negedge clk) begin
    req_t r;
    if (m0_ready) m0_valid = 1'b0;
    if (!m0_valid && m0_pend.size() != 0) begin
      r = m0_pend.pop_front();
      m0_valid = 1'b1;
      m0_wstrb = r.wstrb;
      m0_addr  = r.addr;
      m0_wdata = r.wdata;
      load_cyc0 = cyc;
    end
  end

  always @(negedge clk) begin
    req_t r;
    if (m1_ready) m1_valid = 1'b0;
    if (!m1_valid && m1_pend.size() != 0) begin
      r = m1_pend.pop_front();
      m1_valid = 1'b1;
      m1_wstrb = r.wstrb;
      m1_addr  = r.addr;
      m1_wdata = r.wdata;
      load_cyc1 = cyc;
    end
  end

  // Completion monitor: every ready pulse pops and checks one scoreboard entry.
  always @(negedge clk) begin
    exp_t        e;
    logic        got_m;
    logic [31:0] got_d;
    if (!reset && (m0_ready || m1_ready)) begin
      got_m = m1_ready;
      got_d = m1_ready ? m1_rdata : m0_rdata;
      if (m0_ready) m0_pulses++;
      if (m1_ready) m1_pulses++;
      last_lat = m1_ready ? cyc - load_cyc1 : cyc - load_cyc0;
      checks++;
      if (m0_ready && m1_ready) begin
        errors++;
        $display("FAIL both_ready: m0_ready=1 m1_ready=1, required one-hot");
      end
      checks++;
      if (s_valid !== 1'b0) begin
        errors++;
        $display("FAIL svalid_in_resp: got %b required 0", s_valid);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: master %0d pulsed with nothing expected", got_m);
      end else begin
        e = exp_q.pop_front();
        if (got_m !== e.master || got_d !== e.rdata) begin
          errors++;
          $display("FAIL completion: got master %0d rdata %h required master %0d rdata %h",
                   got_m, got_d, e.master, e.rdata);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    m0_pend.delete();
    m1_pend.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acc_addr.delete();
    acc_wdata.delete();
    acc_wstrb.delete();
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m0_valid && !m1_valid && m0_pend.size() == 0 &&
          m1_pend.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d completions outstanding after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_valid, m0_ready, m1_ready, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: s_valid/m0_ready/m1_ready/timeout_err=%b required 0000",
               {s_valid, m0_ready, m1_ready, timeout_err});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: m0 %h m1 %h required 0", m0_rdata, m1_rdata);
    end
    checks++;
    if (s_wstrb !== 4'h0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_fwd: wstrb %h addr %h wdata %h required 0", s_wstrb, s_addr, s_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int p0 = m0_pulses;
    int p1 = m1_pulses;
    slave_key = 32'h0300_00A5;
    slave_lat = 1;
    @(posedge clk);
    exp_q.push_back('{1'b0, 32'h0000_00A5});
    m0_pend.push_back('{4'h0, 32'h0300_0000, 32'h0});
    wait_drain(20, "single_read");
    checks++;
    if (m0_pulses - p0 != 1 || m1_pulses - p1 != 0) begin
      errors++;
      $display("FAIL single_pulses: m0 %0d m1 %0d required 1 0", m0_pulses - p0, m1_pulses - p1);
    end
    checks++;
    if (last_lat != 3) begin
      errors++;
      $display("FAIL single_latency_lat1: got %0d required 3", last_lat);
    end
    checks++;
    if (acc_addr.size() == 0 || acc_addr[acc_addr.size()-1] !== 32'h0300_0000 ||
        acc_wstrb[acc_wstrb.size()-1] !== 4'h0) begin
      errors++;
      $display("FAIL single_fwd: slave access not seen at 03000000 with wstrb 0");
    end
    // Fastest case: slave answers in the first BUSY cycle.
    slave_key = 32'h1234_0000;
    slave_lat = 0;
    @(posedge clk);
    exp_q.push_back('{1'b0, 32'h0300_0010 ^ 32'h1234_0000});
    m0_pend.push_back('{4'h0, 32'h0300_0010, 32'h0});
    wait_drain(20, "fast_read");
    checks++;
    if (last_lat != 2) begin
      errors++;
      $display("FAIL fast_latency: got %0d required 2", last_lat);
    end
  endtask

  task automatic test_simultaneous_writes();
    do_reset();
    slave_key = 32'hC0DE_0000;
    slave_lat = 0;
    @(posedge clk);
    exp_q.push_back('{1'b0, slave_val(32'h0300_0004, 32'h11)});
    exp_q.push_back('{1'b1, slave_val(32'h0300_0008, 32'h22)});
    m0_pend.push_back('{4'hF, 32'h0300_0004, 32'h11});
    m1_pend.push_back('{4'hF, 32'h0300_0008, 32'h22});
    wait_drain(30, "simul_writes");
    checks++;
    if (acc_wdata.size() != 2) begin
      errors++;
      $display("FAIL simul_access_count: got %0d required 2", acc_wdata.size());
    end else begin
      checks++;
      if (acc_wdata[0] !== 32'h11 || acc_wdata[1] !== 32'h22 || acc_wstrb[0] !== 4'hF) begin
        errors++;
        $display("FAIL simul_order: wdata %h,%h wstrb %h required 11,22 f",
                 acc_wdata[0], acc_wdata[1], acc_wstrb[0]);
      end
    end
  endtask

  task automatic test_alternate();
    int p0, p1;
    do_reset();
    p0 = m0_pulses;
    p1 = m1_pulses;
    slave_key = 32'h5A5A_0000;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a = 32'h0300_0100 + 32'(i * 4);
      logic [31:0] w = 32'(i * 32'h101);
      exp_q.push_back('{1'(i % 2), slave_val(a, w)});
      if (i % 2 == 0) m0_pend.push_back('{4'h0, a, w});
      else            m1_pend.push_back('{4'h0, a, w});
    end
    wait_drain(60, "alternate");
    checks++;
    if (m0_pulses - p0 != 3 || m1_pulses - p1 != 3) begin
      errors++;
      $display("FAIL alt_pulses: m0 %0d m1 %0d required 3 3", m0_pulses - p0, m1_pulses - p1);
    end
    for (int i = 0; i < 6 && i < acc_addr.size(); i++) begin
      checks++;
      if (acc_addr[i] !== 32'h0300_0100 + 32'(i * 4)) begin
        errors++;
        $display("FAIL alt_grant_%0d: addr %h required %h", i, acc_addr[i],
                 32'h0300_0100 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int p0 = m0_pulses;
    int p1 = m1_pulses;
    slave_silent = 1;
    @(posedge clk);
    m0_pend.push_back('{4'h0, 32'h0300_0200, 32'h0});
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (s_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_busy: s_valid never rose, required 1");
    end
    reset = 1'b1;
    m0_valid = 1'b0;
    m0_pend.delete();
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: s_valid %b m0_ready %b m1_ready %b rdata %h required 0 0 0 0",
               s_valid, m0_ready, m1_ready, m0_rdata);
    end
    reset = 1'b0;
    slave_silent = 0;
    slave_key = 32'h0BAD_F00D;
    @(posedge clk);
    exp_q.push_back('{1'b1, slave_val(32'h0300_0204, 32'h0)});
    m1_pend.push_back('{4'h0, 32'h0300_0204, 32'h0});
    wait_drain(20, "post_reset");
    checks++;
    if (m1_pulses - p1 != 1 || m0_pulses != p0) begin
      errors++;
      $display("FAIL post_reset_pulses: m0 %0d m1 %0d required 0 1", m0_pulses - p0, m1_pulses - p1);
    end
  endtask

`ifdef IOMEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    slave_key = 32'h7700_0000;
    slave_lat = int'(TO) - 1;
    @(posedge clk);
    exp_q.push_back('{1'b0, slave_val(32'h0300_0300, 32'h0)});
    m0_pend.push_back('{4'h0, 32'h0300_0300, 32'h0});
    wait_drain(40, "late_ready");
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL late_ready_err: timeout_err %b required 0", timeout_err);
    end
    slave_silent = 1;
    @(posedge clk);
    exp_q.push_back('{1'b1, 32'hFFFF_FFFF});
    m1_pend.push_back('{4'h0, 32'h0300_0304, 32'h0});
    wait_drain(60, "timeout");
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: got %b required 1", timeout_err);
    end
    checks++;
    if (last_lat < int'(TO) + 1 || last_lat > int'(TO) + 2) begin
      errors++;
      $display("FAIL timeout_latency: got %0d required %0d..%0d", last_lat, TO + 1, TO + 2);
    end
    slave_silent = 0;
    slave_lat = 0;
    @(posedge clk);
    exp_q.push_back('{1'b0, slave_val(32'h0300_0308, 32'h0)});
    m0_pend.push_back('{4'h0, 32'h0300_0308, 32'h0});
    wait_drain(20, "after_timeout");
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b required 1", timeout_err);
    end
  endtask
`else
  task automatic test_no_timeout();
    bit seen = 0;
    int p0 = m0_pulses;
    slave_silent = 1;
    slave_lat = 0;
    slave_key = 32'h4400_0000;
    @(posedge clk);
    exp_q.push_back('{1'b0, slave_val(32'h0300_0400, 32'h0)});
    m0_pend.push_back('{4'h0, 32'h0300_0400, 32'h0});
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (s_valid) seen = 1;
    end
    repeat (1000) @(negedge clk);
    checks++;
    if (s_valid !== 1'b1 || m0_pulses != p0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL silent_slave: s_valid %b pulses %0d timeout_err %b required 1 0 0",
               s_valid, m0_pulses - p0, timeout_err);
    end
    slave_silent = 0;
    wait_drain(20, "silent_release");
    checks++;
    if (m0_pulses - p0 != 1) begin
      errors++;
      $display("FAIL silent_release_pulses: got %0d required 1", m0_pulses - p0);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    m0_wstrb = 4'h0;
    m1_wstrb = 4'h0;
    m0_addr  = 32'h0;
    m1_addr  = 32'h0;
    m0_wdata = 32'h0;
    m1_wdata = 32'h0;
    s_ready  = 1'b0;
    s_rdata  = 32'h0;
    test_reset();
    test_single_read();
    test_simultaneous_writes();
    test_alternate();
    test_reset_mid();
`ifdef IOMEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
